// File: rtl/sram_pkg.sv
// sram_pkg: shared types for the SRAM transpose system and its frame sequencer.
//   sfp_t        - one real or imaginary sample word
//   addr_t_long  - SRAM system address; the sequencer only drives the low bits
//   seq_state_e  - frame sequencer states
//   rd_beat_t    - one read-return beat held in the sequencer's output FIFO
package sram_pkg;

   typedef logic [15:0] sfp_t;
   typedef logic [6:0]  addr_t_long;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WRITE  = 2'd1,
      READ   = 2'd2,
      SETTLE = 2'd3
   } seq_state_e;

   // Row-mode write select for row 0 and column-mode read select for column 0.
   localparam logic [4:0] WenRowBase = 5'b00001;
   localparam logic [7:0] RenColBase = 8'h10;

   typedef struct packed {
      sfp_t [3:0] dr;
      sfp_t [3:0] di;
      logic       last;
   } rd_beat_t;

endpackage

// File: rtl/sram_rd_fifo.sv
// sram_rd_fifo: show-ahead synchronous FIFO for read-return beats.
// Ports:
//   clk_i, rst_i    - clock, synchronous active-high reset (empties the FIFO)
//   push_i, data_i  - write one beat; the caller guarantees it is never full
//   pop_i           - consume the head beat (ignored while empty)
//   data_o, valid_o - head beat, valid while non-empty
//   count_o         - current occupancy
module sram_rd_fifo
   import sram_pkg::*;
#(
   parameter int FifoDepth = 4
) (
   input  logic                               clk_i,
   input  logic                               rst_i,
   input  logic                               push_i,
   input  rd_beat_t                           data_i,
   input  logic                               pop_i,
   output rd_beat_t                           data_o,
   output logic                               valid_o,
   output logic [$clog2(FifoDepth + 1) - 1:0] count_o
);

   localparam int PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
   localparam int CntW = $clog2(FifoDepth + 1);

   rd_beat_t        mem_q [FifoDepth];
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] count_q, count_d;
   logic            pop_s;

   // Pointers wrap explicitly so FifoDepth need not be a power of two.
   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(FifoDepth - 1)) ? '0 : p + PtrW'(1);
   endfunction

   assign valid_o = (count_q != '0);
   assign pop_s   = pop_i && valid_o;
   assign data_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

   // Next pointer and occupancy; a simultaneous push and pop leaves occupancy unchanged.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_i) begin
         wr_ptr_d = ptr_inc(wr_ptr_q);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      if (push_i && !pop_s) begin
         count_d = count_q + CntW'(1);
      end else if (pop_s && !push_i) begin
         count_d = count_q - CntW'(1);
      end else begin
         count_d = count_q;
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Beat storage; contents are don't-care while the pointers say empty.
   always_ff @(posedge clk_i) begin
      if (push_i) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

endmodule

// File: rtl/sram_frame_sequencer.sv
// sram_frame_sequencer: writes a frame of 4-lane complex beats into the SRAM
// transpose system row by row, then reads it back column by column.
// Ports:
//   clk_i, rst_i                  - clock, synchronous active-high reset
//   in_valid_i/in_ready_o         - upstream handshake, in_dr_i/in_di_i samples
//   out_valid_o/out_ready_i       - downstream handshake, out_dr_o/out_di_o, out_last_o
//   wen_o, addr_wr_o, d*_sram_o   - row-mode write port (combinational, SRAM registers it)
//   ren_o, addr_rd_o, d*_sram_i   - column-mode read port, data returns two cycles later
//   busy_o                        - not idle
//   frame_done_o                  - pulse once the last read beat is in the FIFO
module sram_frame_sequencer
   import sram_pkg::*;
#(
   parameter int Depth     = 32,
   parameter int FifoDepth = 4
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       in_valid_i,
   output logic       in_ready_o,
   input  sfp_t [3:0] in_dr_i,
   input  sfp_t [3:0] in_di_i,
   output logic       out_valid_o,
   input  logic       out_ready_i,
   output sfp_t [3:0] out_dr_o,
   output sfp_t [3:0] out_di_o,
   output logic       out_last_o,
   output logic [4:0] wen_o,
   output addr_t_long addr_wr_o,
   output sfp_t [3:0] dr_sram_o,
   output sfp_t [3:0] di_sram_o,
   output logic [7:0] ren_o,
   output addr_t_long addr_rd_o,
   input  sfp_t [3:0] dr_sram_i,
   input  sfp_t [3:0] di_sram_i,
   output logic       busy_o,
   output logic       frame_done_o
);

   localparam int               AddrW    = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int               CntW     = $clog2(FifoDepth + 1);
   localparam logic [AddrW-1:0] AddrLast = AddrW'(Depth - 1);
   localparam logic [1:0]       LaneLast = 2'd3;
   localparam logic [CntW:0]    Credits  = (CntW + 1)'(FifoDepth);

   seq_state_e       state_q, state_d;
   logic [1:0]       row_q, row_d;
   logic [1:0]       col_q, col_d;
   logic [AddrW-1:0] addr_q, addr_d;
   logic             settle_q, settle_d;
   logic             done_q, done_d;
   logic [1:0]       iss_q;
   logic [1:0]       iss_last_q;

   logic             wr_hs_s;
   logic             issue_s;
   logic             issue_last_s;
   logic [CntW:0]    occ_s;
   logic [CntW-1:0]  fifo_cnt_s;
   rd_beat_t         push_beat_s;
   rd_beat_t         head_s;
   logic             head_valid_s;

   // Credits: beats already buffered plus reads still travelling through the SRAM.
   assign occ_s = {1'b0, fifo_cnt_s} + (CntW + 1)'(iss_q[0]) + (CntW + 1)'(iss_q[1]);

   // Next-state, counters and SRAM port drive.
   always_comb begin
      state_d      = state_q;
      row_d        = row_q;
      col_d        = col_q;
      addr_d       = addr_q;
      settle_d     = settle_q;
      done_d       = 1'b0;
      in_ready_o   = 1'b0;
      wr_hs_s      = 1'b0;
      issue_s      = 1'b0;
      issue_last_s = 1'b0;
      wen_o        = 5'b00000;
      addr_wr_o    = '0;
      dr_sram_o    = '0;
      di_sram_o    = '0;
      ren_o        = 8'h00;
      addr_rd_o    = '0;
      case (state_q)
         IDLE, WRITE: begin
            in_ready_o = !rst_i;
            wr_hs_s    = in_valid_i && !rst_i;
            if (wr_hs_s) begin
               wen_o     = WenRowBase << row_q;
               addr_wr_o = addr_t_long'(addr_q);
               dr_sram_o = in_dr_i;
               di_sram_o = in_di_i;
               if (addr_q == AddrLast) begin
                  addr_d = '0;
                  row_d  = row_q + 2'd1;
                  if (row_q == LaneLast) begin
                     state_d = READ;
                     col_d   = 2'd0;
                  end else begin
                     state_d = WRITE;
                  end
               end else begin
                  addr_d  = addr_q + AddrW'(1);
                  state_d = WRITE;
               end
            end else begin
               state_d = state_q;
            end
         end
         READ: begin
            ren_o     = RenColBase << col_q;
            addr_rd_o = addr_t_long'(addr_q);
            issue_s   = (occ_s < Credits);
            if (issue_s) begin
               if (addr_q == AddrLast) begin
                  addr_d       = '0;
                  settle_d     = 1'b0;
                  state_d      = SETTLE;
                  issue_last_s = (col_q == LaneLast);
               end else begin
                  addr_d = addr_q + AddrW'(1);
               end
            end else begin
               addr_d = addr_q;
            end
         end
         SETTLE: begin
            // Keep the column select and final address stable while the last reads return.
            ren_o     = RenColBase << col_q;
            addr_rd_o = addr_t_long'(AddrLast);
            if (settle_q) begin
               settle_d = 1'b0;
               col_d    = col_q + 2'd1;
               if (col_q == LaneLast) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d = READ;
               end
            end else begin
               settle_d = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, counters and the two-stage read-issue tracker.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         row_q      <= 2'd0;
         col_q      <= 2'd0;
         addr_q     <= '0;
         settle_q   <= 1'b0;
         done_q     <= 1'b0;
         iss_q      <= 2'b00;
         iss_last_q <= 2'b00;
      end else begin
         state_q    <= state_d;
         row_q      <= row_d;
         col_q      <= col_d;
         addr_q     <= addr_d;
         settle_q   <= settle_d;
         done_q     <= done_d;
         iss_q      <= {iss_q[0], issue_s};
         iss_last_q <= {iss_last_q[0], issue_last_s};
      end
   end

   assign push_beat_s = '{dr: dr_sram_i, di: di_sram_i, last: iss_last_q[1]};

   sram_rd_fifo #(
      .FifoDepth (FifoDepth)
   ) u_rd_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (iss_q[1]),
      .data_i  (push_beat_s),
      .pop_i   (out_ready_i),
      .data_o  (head_s),
      .valid_o (head_valid_s),
      .count_o (fifo_cnt_s)
   );

   assign out_valid_o  = head_valid_s;
   assign out_dr_o     = head_s.dr;
   assign out_di_o     = head_s.di;
   assign out_last_o   = head_valid_s && head_s.last;
   assign busy_o       = (state_q != IDLE);
   assign frame_done_o = done_q;

endmodule
